sys_arr_skewed: RTL and testbench



---
 rtl/sys_arr_skewed_if.sv | 28 ++
 rtl/sys_arr_skewed.sv | 218 +++++++++++++++++++++
 tb/tb_sys_arr_skewed.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/sys_arr_skewed_if.sv
// Stream bundle for sys_arr_skewed: weight-row, activation-vector and result
// channels, each with a valid/ready handshake. The array uses the slave modport.
interface sys_arr_skewed_if #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
);
  logic                     w_valid;
  logic                     w_ready;
  logic [COLS*DATA_W-1:0]   w_data;
  logic                     in_valid;
  logic                     in_ready;
  logic [ROWS*DATA_W-1:0]   in_data;
  logic                     out_valid;
  logic                     out_ready;
  logic [COLS*ACC_W-1:0]    out_data;

  modport master (
    output w_valid, w_data, in_valid, in_data, out_ready,
    input  w_ready, in_ready, out_valid, out_data
  );

  modport slave (
    input  w_valid, w_data, in_valid, in_data, out_ready,
    output w_ready, in_ready, out_valid, out_data
  );
endinterface

// File: rtl/sys_arr_skewed.sv
// Weight-stationary ROWS x COLS systolic matrix-vector unit.
// out[c] = sum_r x[r] * W[r][c], with input skew, output deskew, a weight-load
// FSM (LOAD/RUN/DRAIN) and whole-pipeline stall on result backpressure.
// Optional build macro: SYS_ARR_SAT_EN (saturating accumulate at every row;
// default build wraps modulo 2^ACC_W).
module sys_arr_skewed #(
  parameter int ROWS   = 4,
  parameter int COLS   = 4,
  parameter int DATA_W = 8,
  parameter int ACC_W  = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  sys_arr_skewed_if.slave      bus
);

  localparam int NTOK  = ROWS + COLS;
  localparam int CNT_W = $clog2(ROWS + 1);

  typedef enum logic [1:0] {
    S_LOAD  = 2'd0,
    S_RUN   = 2'd1,
    S_DRAIN = 2'd2
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [CNT_W-1:0]        r_cnt;
  logic [CNT_W-1:0]        w_cnt_nxt;
  logic [NTOK-1:0]         r_tok;
  logic                    w_stall;
  logic                    w_in_ready;
  logic                    w_w_ready;
  logic                    w_in_fire;
  logic                    w_w_fire;

  logic signed [DATA_W-1:0] r_w   [ROWS][COLS];
  logic signed [DATA_W-1:0] r_a   [ROWS][COLS];
  logic signed [ACC_W-1:0]  r_s   [ROWS][COLS];
  logic signed [DATA_W-1:0] w_ain [ROWS][COLS];
  logic signed [ACC_W-1:0]  w_sin [ROWS][COLS];
  logic signed [DATA_W-1:0] w_x   [ROWS];
  logic signed [ACC_W-1:0]  w_out [COLS];

  // One PE step: signed product, sign-extended, added to the incoming sum.
  function automatic logic signed [ACC_W-1:0] f_mac(
    input logic signed [ACC_W-1:0]  s,
    input logic signed [DATA_W-1:0] a,
    input logic signed [DATA_W-1:0] w
  );
    logic signed [2*DATA_W-1:0] p;
`ifdef SYS_ARR_SAT_EN
    logic signed [ACC_W:0]      t;
    p = (2*DATA_W)'(a) * (2*DATA_W)'(w);
    t = (ACC_W+1)'(s) + (ACC_W+1)'(p);
    if (t[ACC_W] != t[ACC_W-1])
      return t[ACC_W] ? {1'b1, {(ACC_W-1){1'b0}}} : {1'b0, {(ACC_W-1){1'b1}}};
    return t[ACC_W-1:0];
`else
    p = (2*DATA_W)'(a) * (2*DATA_W)'(w);
    return s + ACC_W'(p);
`endif
  endfunction

  assign bus.out_valid = r_tok[NTOK-1];
  assign w_stall       = r_tok[NTOK-1] && !bus.out_ready;
  assign w_in_fire     = bus.in_valid && w_in_ready;
  assign w_w_fire      = bus.w_valid && w_w_ready && !w_stall;
  assign bus.in_ready  = w_in_ready;
  assign bus.w_ready   = w_w_ready;

  // FSM next-state, load counter and handshake readies.
  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_w_ready   = 1'b0;
    w_in_ready  = 1'b0;
    unique case (r_state)
      S_LOAD: begin
        w_w_ready = 1'b1;
        if (bus.w_valid) begin
          if (r_cnt == CNT_W'(ROWS - 1)) begin
            w_state_nxt = S_RUN;
            w_cnt_nxt   = '0;
          end else begin
            w_cnt_nxt = r_cnt + 1'b1;
          end
        end
      end
      S_RUN: begin
        w_in_ready = !w_stall;
        if (bus.w_valid) w_state_nxt = S_DRAIN;
      end
      S_DRAIN: begin
        if (r_tok == '0) begin
          w_state_nxt = S_LOAD;
          w_cnt_nxt   = '0;
        end
      end
      default: begin
        w_state_nxt = S_LOAD;
        w_cnt_nxt   = '0;
      end
    endcase
  end

  // FSM state and load counter; frozen during stall like everything else.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= S_LOAD;
      r_cnt   <= '0;
    end else if (!w_stall) begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
    end
  end

  // Valid token travels alongside each accepted vector.
  always_ff @(posedge clk) begin
    if (reset) r_tok <= '0;
    else if (!w_stall) r_tok <= {r_tok[NTOK-2:0], w_in_fire};
  end

  // Weight rows shift down one row per accepted beat, then stay put.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          r_w[r][c] <= '0;
    end else if (w_w_fire) begin
      for (int unsigned c = 0; c < COLS; c++)
        r_w[0][c] <= bus.w_data[c*DATA_W +: DATA_W];
      for (int unsigned r = 1; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++)
          r_w[r][c] <= r_w[r-1][c];
    end
  end

  // Input skew: stage 0 captures the vector, row r adds r further stages.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_skew
    logic signed [DATA_W-1:0] r_line [gr+1];

    // Skew shift line for this row.
    always_ff @(posedge clk) begin
      if (reset) begin
        for (int unsigned k = 0; k < gr + 1; k++) r_line[k] <= '0;
      end else if (!w_stall) begin
        r_line[0] <= w_in_fire ? bus.in_data[gr*DATA_W +: DATA_W] : '0;
        for (int unsigned k = 1; k < gr + 1; k++) r_line[k] <= r_line[k-1];
      end
    end

    assign w_x[gr] = r_line[gr];
  end

  // PE operand routing: activations enter at column 0, sums enter at row 0 as 0.
  for (genvar gr = 0; gr < ROWS; gr++) begin : g_row
    for (genvar gc = 0; gc < COLS; gc++) begin : g_col
      if (gc == 0) begin : g_ain0
        assign w_ain[gr][gc] = w_x[gr];
      end else begin : g_ainn
        assign w_ain[gr][gc] = r_a[gr][gc-1];
      end
      if (gr == 0) begin : g_sin0
        assign w_sin[gr][gc] = '0;
      end else begin : g_sinn
        assign w_sin[gr][gc] = r_s[gr-1][gc];
      end
    end
  end

  // PE array registers: activation moves right, partial sum moves down.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++) begin
          r_a[r][c] <= '0;
          r_s[r][c] <= '0;
        end
    end else if (!w_stall) begin
      for (int unsigned r = 0; r < ROWS; r++)
        for (int unsigned c = 0; c < COLS; c++) begin
          r_a[r][c] <= w_ain[r][c];
          r_s[r][c] <= f_mac(w_sin[r][c], w_ain[r][c], r_w[r][c]);
        end
    end
  end

  // Output deskew: column c waits COLS-1-c cycles so all columns align.
  for (genvar gc = 0; gc < COLS; gc++) begin : g_deskew
    if (gc == COLS - 1) begin : g_direct
      assign w_out[gc] = r_s[ROWS-1][gc];
    end else begin : g_dly
      localparam int D = COLS - 1 - gc;
      logic signed [ACC_W-1:0] r_dly [D];

      // Deskew delay line for this column.
      always_ff @(posedge clk) begin
        if (reset) begin
          for (int unsigned k = 0; k < D; k++) r_dly[k] <= '0;
        end else if (!w_stall) begin
          r_dly[0] <= r_s[ROWS-1][gc];
          for (int unsigned k = 1; k < D; k++) r_dly[k] <= r_dly[k-1];
        end
      end

      assign w_out[gc] = r_dly[D-1];
    end
  end

  // Pack aligned column results onto the result bus, column 0 in LSBs.
  always_comb begin
    bus.out_data = '0;
    for (int unsigned c = 0; c < COLS; c++)
      bus.out_data[c*ACC_W +: ACC_W] = w_out[c];
  end

endmodule

// File: tb/tb_sys_arr_skewed.sv
// Directed bench for sys_arr_skewed (4x4, 8-bit data, 16-bit results).
// Inputs driven 1 ns after the rising edge, outputs sampled on the falling edge.
module tb_sys_arr_skewed;
  localparam int ROWS = 4, COLS = 4, DATA_W = 8, ACC_W = 16;

`ifdef SYS_ARR_SAT_EN
  localparam logic [63:0] EXP_BIG = 64'h7FFF_7FFF_7FFF_7FFF;
`else
  localparam logic [63:0] EXP_BIG = 64'hFC04_FC04_FC04_FC04;
`endif

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sys_arr_skewed_if #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) bus ();

  sys_arr_skewed #(.ROWS(ROWS), .COLS(COLS), .DATA_W(DATA_W), .ACC_W(ACC_W)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_asserts = 0;
  int n_fail    = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_asserts++;
    assert (got === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  // Advance to the falling edge of the first cycle with out_valid high.
  task automatic wait_valid(input string tag);
    logic found;
    found = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) begin
        found = 1'b1;
        break;
      end
    end
    chk({tag, "_timeout"}, 64'(found), 64'd1);
  endtask

  task automatic send_in(input string tag, input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data  = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.in_ready === 1'b1) ok = 1'b1;
      step();
      if (ok) break;
    end
    bus.in_valid = 1'b0;
    chk({tag, "_in_timeout"}, 64'(ok), 64'd1);
  endtask

  task automatic send_w(input logic [31:0] d);
    logic ok;
    ok = 1'b0;
    bus.w_valid = 1'b1;
    bus.w_data  = d;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.w_ready === 1'b1) ok = 1'b1;
      step();
      if (ok) break;
    end
    chk("w_beat_timeout", 64'(ok), 64'd1);
  endtask

  // Rows given top to bottom; beats go out bottom row first.
  task automatic load_w(input logic [31:0] r0, input logic [31:0] r1,
                        input logic [31:0] r2, input logic [31:0] r3);
    send_w(r3);
    send_w(r2);
    send_w(r1);
    send_w(r0);
    bus.w_valid = 1'b0;
  endtask

  function automatic logic [31:0] vin(input int k);
    logic [31:0] v;
    for (int r = 0; r < ROWS; r++) v[r*8 +: 8] = 8'(10*k + r + 1);
    return v;
  endfunction

  function automatic logic [63:0] vout(input int k);
    logic [63:0] v;
    for (int c = 0; c < COLS; c++) v[c*16 +: 16] = 16'(10*k + c + 1);
    return v;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int sent, got, stalls, seen;
    logic have_held;
    logic [63:0] held;

    reset         = 1'b1;
    bus.w_valid   = 1'b0;
    bus.w_data    = '0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b1;
    step();
    step();
    @(negedge clk);
    chk("rst_w_ready",   64'(bus.w_ready),   64'd1);
    chk("rst_in_ready",  64'(bus.in_ready),  64'd0);
    chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
    chk("rst_out_data",  bus.out_data,       64'd0);
    step();
    reset = 1'b0;

    // Identity weights, single vector, exact latency.
    load_w(32'h0000_0001, 32'h0000_0100, 32'h0001_0000, 32'h0100_0000);
    @(negedge clk);
    chk("run_in_ready", 64'(bus.in_ready), 64'd1);
    chk("run_w_ready",  64'(bus.w_ready),  64'd0);
    step();
    send_in("t1", 32'h0403_0201);
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      chk("t1_early_valid", 64'(bus.out_valid), 64'd0);
      step();
    end
    @(negedge clk);
    chk("t1_valid", 64'(bus.out_valid), 64'd1);
    chk("t1_data",  bus.out_data, 64'h0004_0003_0002_0001);
    step();

    // Three back-to-back vectors, three consecutive results.
    send_in("t2a", 32'h0101_0101);
    send_in("t2b", 32'h0202_0202);
    send_in("t2c", 32'h0303_0303);
    wait_valid("t2");
    chk("t2_data0", bus.out_data, 64'h0001_0001_0001_0001);
    step();
    @(negedge clk);
    chk("t2_valid1", 64'(bus.out_valid), 64'd1);
    chk("t2_data1",  bus.out_data, 64'h0002_0002_0002_0002);
    step();
    @(negedge clk);
    chk("t2_valid2", 64'(bus.out_valid), 64'd1);
    chk("t2_data2",  bus.out_data, 64'h0003_0003_0003_0003);
    step();
    @(negedge clk);
    chk("t2_no_extra", 64'(bus.out_valid), 64'd0);
    step();

    // Six streamed vectors with out_ready low for cycles 9..13.
    sent = 0; got = 0; stalls = 0; have_held = 1'b0; held = '0;
    for (int cyc = 0; cyc < 60 && got < 6; cyc++) begin
      bus.in_valid  = (sent < 6);
      bus.in_data   = vin(sent);
      bus.out_ready = !(cyc >= 9 && cyc <= 13);
      @(negedge clk);
      if (bus.out_valid === 1'b1 && bus.out_ready === 1'b0) begin
        stalls++;
        if (have_held) chk("t4_hold", bus.out_data, held);
        held      = bus.out_data;
        have_held = 1'b1;
      end else if (bus.out_valid === 1'b1) begin
        chk("t4_data", bus.out_data, vout(got));
        got++;
        have_held = 1'b0;
      end
      if (bus.in_valid && bus.in_ready === 1'b1) sent++;
      step();
    end
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b1;
    chk("t4_count",  64'(got),    64'd6);
    chk("t4_stalls", 64'(stalls), 64'd5);
    @(negedge clk);
    chk("t4_no_extra", 64'(bus.out_valid), 64'd0);
    step();

    // Reload request coincident with an activation beat.
    bus.w_valid = 1'b1;
    bus.w_data  = 32'hFFFF_FFFF;
    send_in("t5", 32'h0807_0605);
    @(negedge clk);
    chk("t5_in_ready_drop", 64'(bus.in_ready), 64'd0);
    chk("t5_w_ready_drain", 64'(bus.w_ready),  64'd0);
    step();
    wait_valid("t5_old");
    chk("t5_old_data",      bus.out_data,       64'h0008_0007_0006_0005);
    chk("t5_w_ready_at_hs", 64'(bus.w_ready),   64'd0);
    step();
    load_w(32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF);
    send_in("t5_new", 32'h7F7F_7F7F);
    wait_valid("t5_new");
    chk("t5_neg_data", bus.out_data, 64'hFE04_FE04_FE04_FE04);
    step();

    // Overflowing accumulation: saturate or wrap depending on build.
    load_w(32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7F7F_7F7F, 32'h7F7F_7F7F);
    send_in("t6", 32'h7F7F_7F7F);
    wait_valid("t6");
    chk("t6_big_data", bus.out_data, EXP_BIG);
    step();

    // Reset with a vector in flight, then a partial weight load.
    send_in("t7", vin(1));
    step();
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    @(negedge clk);
    chk("t7_out_valid", 64'(bus.out_valid), 64'd0);
    chk("t7_out_data",  bus.out_data,       64'd0);
    chk("t7_w_ready",   64'(bus.w_ready),   64'd1);
    step();
    bus.w_valid = 1'b1;
    bus.w_data  = 32'h0102_0304;
    step();
    step();
    bus.w_valid = 1'b0;
    seen = 0;
    for (int i = 0; i < 12; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
      step();
    end
    chk("t7_discarded", 64'(seen), 64'd0);
    @(negedge clk);
    chk("t7_partial_in_ready", 64'(bus.in_ready), 64'd0);
    chk("t7_partial_w_ready",  64'(bus.w_ready),  64'd1);
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_asserts, n_fail);
    $finish;
  end
endmodule
